// File: rtl/ikaopll_bus_write_sequencer.sv
// ---------------------------------------------------------------------------
// ikaopll_bus_write_sequencer
//
// Purpose: queues (A0, data) register writes from a host / VGM front end and
// replays them onto the IKAOPLL CPU bus with phiM-aligned setup, strobe and
// hold timing. After each write it holds the bus idle for a minimum recovery
// gap that depends on the write type (address vs data).
//
// Optional feature: define IKAOPLL_WRSEQ_STATS_EN to build the saturating
// write / stall statistics counters. Without it the stat ports read 0.
//
// Ports:
//   i_EMUCLK        system clock (IKAOPLL emulation clock)
//   i_RST           synchronous reset, active-high
//   i_PHIM_PCEN     one-cycle phiM enable pulse; every FSM step gates on it
//   i_WR_VALID      write request valid
//   o_WR_READY      queue can accept (not full)
//   i_WR_A0         0 = address write, 1 = data write
//   i_WR_DATA[7:0]  write byte
//   i_FLUSH         drop all queued entries (in-flight write completes)
//   o_CS_n, o_WR_n  bus strobes to IKAOPLL
//   o_A0, o_D[7:0]  bus address select / data to IKAOPLL
//   o_BUSY          FSM not idle or queue non-empty
//   o_LEVEL         queue occupancy
//   o_STAT_WRITES   completed-write count (saturating)
//   o_STAT_STALL    phiM cycles spent in recovery with work queued (saturating)
// ---------------------------------------------------------------------------
module ikaopll_bus_write_sequencer #(
  parameter int FIFO_DEPTH    = 16,
  parameter int STROBE_CYC    = 1,
  parameter int MIN_WAIT_ADDR = 12,
  parameter int MIN_WAIT_DATA = 84
) (
  input  logic                              i_EMUCLK,
  input  logic                              i_RST,
  input  logic                              i_PHIM_PCEN,
  input  logic                              i_WR_VALID,
  output logic                              o_WR_READY,
  input  logic                              i_WR_A0,
  input  logic [7:0]                        i_WR_DATA,
  input  logic                              i_FLUSH,
  output logic                              o_CS_n,
  output logic                              o_WR_n,
  output logic                              o_A0,
  output logic [7:0]                        o_D,
  output logic                              o_BUSY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_LEVEL,
  output logic [15:0]                       o_STAT_WRITES,
  output logic [15:0]                       o_STAT_STALL
);

  localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int WAIT_MAX = (MIN_WAIT_ADDR > MIN_WAIT_DATA) ? MIN_WAIT_ADDR : MIN_WAIT_DATA;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int STB_W    = $clog2(STROBE_CYC + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;

  // -------------------------------------------------------------------------
  // Write queue: 9-bit entries {A0, data}
  // -------------------------------------------------------------------------
  logic [8:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [8:0]       w_head;

  logic [2:0]       r_state;
  logic             r_cs_n;
  logic             r_wr_n;
  logic             r_a0;
  logic [7:0]       r_d;
  logic [STB_W-1:0] r_stb_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;

  assign w_full  = (r_count == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // A flush discards a same-cycle push and also suppresses a same-cycle pop,
  // so nothing queued at the moment of the flush can still reach the bus.
  // Readiness is judged on the registered count only: a pop in the same cycle
  // does not open a slot for a push into a full queue.
  assign w_push = i_WR_VALID && !w_full && !i_FLUSH;
  assign w_pop  = i_PHIM_PCEN && (r_state == ST_IDLE) && !w_empty && !i_FLUSH;

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge i_EMUCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_WR_A0, i_WR_DATA};
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_FLUSH) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Bus FSM: IDLE -> SETUP -> STROBE -> HOLD -> WAIT -> IDLE
  // The wait counter is loaded at the STROBE->HOLD step and counts down once
  // per phiM, so the FSM re-enters IDLE MIN_WAIT phiM after WR_n rises; the
  // IDLE pop and SETUP step then add two more phiM before the next strobe.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_state    <= ST_IDLE;
      r_cs_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_a0       <= 1'b0;
      r_d        <= 8'h00;
      r_stb_cnt  <= '0;
      r_wait_cnt <= '0;
    end else if (i_PHIM_PCEN) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_a0    <= w_head[8];
            r_d     <= w_head[7:0];
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_cs_n    <= 1'b0;
          r_wr_n    <= 1'b0;
          r_stb_cnt <= STB_W'(STROBE_CYC);
          r_state   <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_stb_cnt <= STB_W'(1)) begin
            r_stb_cnt  <= '0;
            r_cs_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_wait_cnt <= r_a0 ? WAIT_W'(MIN_WAIT_DATA) : WAIT_W'(MIN_WAIT_ADDR);
            r_state    <= ST_HOLD;
          end else begin
            r_stb_cnt <= r_stb_cnt - STB_W'(1);
          end
        end
        ST_HOLD, ST_WAIT: begin
          if (r_wait_cnt <= WAIT_W'(1)) begin
            r_wait_cnt <= '0;
            r_d        <= 8'h00;
            r_state    <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
            r_state    <= ST_WAIT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_CS_n     = r_cs_n;
  assign o_WR_n     = r_wr_n;
  assign o_A0       = r_a0;
  assign o_D        = r_d;
  assign o_WR_READY = !w_full;
  assign o_BUSY     = (r_state != ST_IDLE) || !w_empty;
  assign o_LEVEL    = r_count;

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
`ifdef IKAOPLL_WRSEQ_STATS_EN
  logic [15:0] r_stat_writes;
  logic [15:0] r_stat_stall;
  logic        w_write_done;
  logic        w_stall;

  assign w_write_done = i_PHIM_PCEN && (r_state == ST_STROBE) && (r_stb_cnt <= STB_W'(1));
  assign w_stall      = i_PHIM_PCEN && ((r_state == ST_HOLD) || (r_state == ST_WAIT)) && !w_empty;

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_stat_writes <= 16'h0000;
      r_stat_stall  <= 16'h0000;
    end else begin
      if (w_write_done && (r_stat_writes != 16'hFFFF)) r_stat_writes <= r_stat_writes + 16'd1;
      if (w_stall && (r_stat_stall != 16'hFFFF))       r_stat_stall  <= r_stat_stall + 16'd1;
    end
  end

  assign o_STAT_WRITES = r_stat_writes;
  assign o_STAT_STALL  = r_stat_stall;
`else
  assign o_STAT_WRITES = 16'h0000;
  assign o_STAT_STALL  = 16'h0000;
`endif

endmodule

// File: tb/tb_ikaopll_bus_write_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for ikaopll_bus_write_sequencer (default parameters,
// PCEN once every 4 clocks). A monitor records WR_n edges and BUSY drops in
// units of phiM periods; each test task checks those records against
// hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ikaopll_bus_write_sequencer;

  logic        clk;
  logic        rst;
  logic        pcen;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_a0;
  logic [7:0]  wr_data;
  logic        flush;
  logic        cs_n;
  logic        wr_n;
  logic        a0;
  logic [7:0]  d;
  logic        busy;
  logic [4:0]  level;
  logic [15:0] stat_writes;
  logic [15:0] stat_stall;

  int n_vec;
  int n_err;

  logic pcen_en;

  // monitor records
  int          phim;
  int          fall_t[$];
  int          rise_t[$];
  logic [8:0]  fall_ad[$];
  logic [8:0]  setup_ad[$];
  int          busy_fall_t;

  ikaopll_bus_write_sequencer dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_PHIM_PCEN   (pcen),
    .i_WR_VALID    (wr_valid),
    .o_WR_READY    (wr_ready),
    .i_WR_A0       (wr_a0),
    .i_WR_DATA     (wr_data),
    .i_FLUSH       (flush),
    .o_CS_n        (cs_n),
    .o_WR_n        (wr_n),
    .o_A0          (a0),
    .o_D           (d),
    .o_BUSY        (busy),
    .o_LEVEL       (level),
    .o_STAT_WRITES (stat_writes),
    .o_STAT_STALL  (stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PCEN: one pulse every 4th clock while enabled, driven on the falling edge
  initial begin
    int pcnt;
    pcnt = 0;
    pcen = 1'b0;
    forever begin
      @(negedge clk);
      if (pcen_en) begin
        pcnt = (pcnt + 1) % 4;
        pcen = (pcnt == 0);
      end else begin
        pcen = 1'b0;
      end
    end
  end

  // Bus monitor: phim counts PCEN edges; fall/rise times are in phim units.
  initial begin
    logic       pc;
    logic       prev_wr;
    logic       prev_busy;
    logic [8:0] prev_ad;
    phim        = 0;
    prev_wr     = 1'b1;
    prev_busy   = 1'b0;
    prev_ad     = 9'h000;
    busy_fall_t = -1;
    forever begin
      @(posedge clk);
      pc = pcen;
      #1;
      if (pc) phim++;
      if (prev_wr && !wr_n) begin
        fall_t.push_back(phim);
        fall_ad.push_back({a0, d});
        setup_ad.push_back(prev_ad);
      end
      if (!prev_wr && wr_n) rise_t.push_back(phim);
      if (prev_busy && !busy) busy_fall_t = phim;
      if (pc) prev_ad = {a0, d};
      prev_wr   = wr_n;
      prev_busy = busy;
    end
  end

  task automatic clear_records();
    fall_t.delete();
    rise_t.delete();
    fall_ad.delete();
    setup_ad.delete();
    busy_fall_t = -1;
  endtask

  task automatic push(input logic a, input logic [7:0] b);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_a0    = a;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((busy || !wr_n) && n < max_cyc);
    n_vec++;
    if (busy || !wr_n) begin
      n_err++;
      $display("FAIL %s_idle_timeout: busy=%0b wr_n=%0b after %0d clocks, required idle", name, busy, wr_n, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_vec++; if (cs_n !== 1'b1)      begin n_err++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
    n_vec++; if (wr_n !== 1'b1)      begin n_err++; $display("FAIL rst_wr_n: got %b want 1", wr_n); end
    n_vec++; if (level !== 5'd0)     begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_vec++; if (wr_ready !== 1'b1)  begin n_err++; $display("FAIL rst_ready: got %b want 1", wr_ready); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (d !== 8'h00)        begin n_err++; $display("FAIL rst_d: got %h want 00", d); end
    n_vec++; if (a0 !== 1'b0)        begin n_err++; $display("FAIL rst_a0: got %b want 0", a0); end
    n_vec++; if (stat_writes !== 16'h0 || stat_stall !== 16'h0) begin
      n_err++; $display("FAIL rst_stats: got %h/%h want 0000/0000", stat_writes, stat_stall);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_addr();
    clear_records();
    push(1'b0, 8'h10);
    wait_idle(1000, "single");
    n_vec++;
    if (fall_t.size() != 1 || rise_t.size() != 1) begin
      n_err++; $display("FAIL single_strobes: got %0d falls %0d rises want 1/1", fall_t.size(), rise_t.size());
    end else begin
      n_vec++; if (fall_ad[0] !== 9'h010) begin n_err++; $display("FAIL single_bus_value: got %h want 010", fall_ad[0]); end
      n_vec++; if (setup_ad[0] !== 9'h010) begin n_err++; $display("FAIL single_setup: got %h want 010", setup_ad[0]); end
      n_vec++; if (rise_t[0] - fall_t[0] != 1) begin n_err++; $display("FAIL single_strobe_width: got %0d want 1", rise_t[0] - fall_t[0]); end
      n_vec++; if (busy_fall_t - rise_t[0] != 12) begin n_err++; $display("FAIL single_busy_drop: got %0d want 12", busy_fall_t - rise_t[0]); end
    end
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL single_d_return: got %h want 00", d); end
`ifdef IKAOPLL_WRSEQ_STATS_EN
    n_vec++; if (stat_writes !== 16'd1) begin n_err++; $display("FAIL single_stat_writes: got %0d want 1", stat_writes); end
`endif
    $display("test_single_addr done: %0d strobe(s)", fall_t.size());
  endtask

  task automatic test_back_to_back();
    clear_records();
    @(negedge clk);
    wr_valid = 1'b1; wr_a0 = 1'b0; wr_data = 8'h10;
    @(negedge clk);
    wr_a0 = 1'b1; wr_data = 8'hAB;
    @(negedge clk);
    wr_a0 = 1'b0; wr_data = 8'h20;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_idle(2000, "b2b");
    n_vec++;
    if (fall_t.size() != 3 || rise_t.size() != 3) begin
      n_err++; $display("FAIL b2b_strobes: got %0d falls %0d rises want 3/3", fall_t.size(), rise_t.size());
    end else begin
      n_vec++; if (fall_ad[0] !== 9'h010) begin n_err++; $display("FAIL b2b_order0: got %h want 010", fall_ad[0]); end
      n_vec++; if (fall_ad[1] !== 9'h1AB) begin n_err++; $display("FAIL b2b_order1: got %h want 1ab", fall_ad[1]); end
      n_vec++; if (fall_ad[2] !== 9'h020) begin n_err++; $display("FAIL b2b_order2: got %h want 020", fall_ad[2]); end
      n_vec++; if (fall_t[1] - rise_t[0] != 14) begin n_err++; $display("FAIL b2b_gap_addr: got %0d want 14", fall_t[1] - rise_t[0]); end
      n_vec++; if (fall_t[2] - rise_t[1] != 86) begin n_err++; $display("FAIL b2b_gap_data: got %0d want 86", fall_t[2] - rise_t[1]); end
      n_vec++; if (rise_t[1] - fall_t[1] != 1) begin n_err++; $display("FAIL b2b_strobe_width: got %0d want 1", rise_t[1] - fall_t[1]); end
    end
    $display("test_back_to_back done: %0d strobe(s)", fall_t.size());
  endtask

  task automatic test_full();
    int bad;
    clear_records();
    pcen_en = 1'b0;
    for (int i = 0; i < 16; i++) push(1'b0, 8'h40 + 8'(i));
    #1;
    n_vec++; if (level !== 5'd16)   begin n_err++; $display("FAIL full_level: got %0d want 16", level); end
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", wr_ready); end
    push(1'b0, 8'h50);
    #1;
    n_vec++; if (level !== 5'd16)   begin n_err++; $display("FAIL full_reject: level got %0d want 16", level); end
    n_vec++; if (fall_t.size() != 0) begin n_err++; $display("FAIL full_frozen: got %0d strobes want 0", fall_t.size()); end
    pcen_en = 1'b1;
    wait_idle(6000, "full");
    n_vec++;
    if (fall_t.size() != 16) begin
      n_err++; $display("FAIL full_emitted: got %0d strobes want 16", fall_t.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 16; i++) if (fall_ad[i] !== (9'h040 + 9'(i))) bad++;
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL full_order: got %0d wrong bytes want 0", bad); end
    end
    $display("test_full done: %0d strobe(s)", fall_t.size());
  endtask

  task automatic test_flush();
    int n;
    clear_records();
    pcen_en = 1'b0;
    for (int i = 0; i < 6; i++) push(1'b1, 8'h60 + 8'(i));
    pcen_en = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (wr_n && n < 200);
    n_vec++; if (wr_n !== 1'b0) begin n_err++; $display("FAIL flush_strobe_timeout: wr_n got %b want 0", wr_n); end
    n_vec++; if (level !== 5'd5) begin n_err++; $display("FAIL flush_pre_level: got %0d want 5", level); end
    @(negedge clk);
    flush = 1'b1; wr_valid = 1'b1; wr_a0 = 1'b0; wr_data = 8'h77;
    @(posedge clk); #1;
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", level); end
    @(negedge clk);
    flush = 1'b0; wr_valid = 1'b0;
    wait_idle(2000, "flush");
    repeat (100) @(posedge clk);
    #1;
    n_vec++; if (fall_t.size() != 1 || rise_t.size() != 1) begin
      n_err++; $display("FAIL flush_strobes: got %0d falls %0d rises want 1/1", fall_t.size(), rise_t.size());
    end
    $display("test_flush done: %0d strobe(s)", fall_t.size());
  endtask

  task automatic test_reset_mid_strobe();
    int n;
    int p0;
    clear_records();
    push(1'b1, 8'hC3);
    push(1'b0, 8'h11);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (wr_n && n < 200);
    n_vec++; if (wr_n !== 1'b0) begin n_err++; $display("FAIL rstmid_strobe_timeout: wr_n got %b want 0", wr_n); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (wr_n !== 1'b1 || cs_n !== 1'b1) begin n_err++; $display("FAIL rstmid_strobes: got wr_n=%b cs_n=%b want 1/1", wr_n, cs_n); end
    n_vec++; if (level !== 5'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_queue: got level=%0d busy=%b want 0/0", level, busy); end
    n_vec++; if (stat_writes !== 16'h0 || stat_stall !== 16'h0) begin
      n_err++; $display("FAIL rstmid_stats: got %h/%h want 0000/0000", stat_writes, stat_stall);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_records();
    @(negedge clk);
    p0 = phim;
    wr_valid = 1'b1; wr_a0 = 1'b0; wr_data = 8'h33;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_idle(1000, "rstmid");
    n_vec++;
    if (fall_t.size() != 1) begin
      n_err++; $display("FAIL rstmid_post_strobes: got %0d want 1", fall_t.size());
    end else begin
      n_vec++; if (fall_t[0] - p0 > 3) begin n_err++; $display("FAIL rstmid_latency: got %0d phiM want <=3", fall_t[0] - p0); end
      n_vec++; if (fall_ad[0] !== 9'h033) begin n_err++; $display("FAIL rstmid_bus_value: got %h want 033", fall_ad[0]); end
    end
    $display("test_reset_mid_strobe done: %0d strobe(s)", fall_t.size());
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    pcen_en  = 1'b1;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_a0    = 1'b0;
    wr_data  = 8'h00;
    flush    = 1'b0;
    test_reset();
    test_single_addr();
    test_back_to_back();
    test_full();
    test_flush();
    test_reset_mid_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
